instruction_memory_loader: RTL and testbench
============================================

# instruction_memory_loader

Loads a program into the MIPS instruction memory from a byte stream, e.g. the output of the UART receiver in the debug unit. It is the write side of the instruction memory that `tl_instruction_fetch` reads. It assembles incoming bytes into 32-bit big-endian words and issues one write per word at consecutive word addresses. It stops on the HALT word or when memory is full, then flags load completion so the fetch stage may be released.

## Interface

Parameters:
- `len`, 32, instruction/data width in bits; must be 32.
- `N_ADDR`, 10, word-address width; memory depth = 2^N_ADDR words.
- `HALT_WORD`, 32'hFFFFFFFF, word that terminates the load. It is itself written to memory.

Ports:
- `i_clk`  in  1  clock, rising-edge.
- `i_rst`  in  1  reset, asynchronous, active-low (0 = reset, 1 = run).
- `i_start`  in  1  one-cycle pulse; begins a load at word address 0 (accepted in IDLE and DONE only).
- `i_rx_done`  in  1  one-cycle pulse; `i_rx_data` is valid this cycle.
- `i_rx_data`  in  8  received byte.
- `o_wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `o_wr_addr`  out  N_ADDR  word address of the write.
- `o_wr_data`  out  len  assembled instruction.
- `o_load_done`  out  1  high while in DONE.
- `o_busy`  out  1  high while in COLLECT.
- `o_word_count`  out  N_ADDR+1  number of words written in the current/last load, HALT word included.

## Operation

- States: IDLE, COLLECT, DONE.
- Reset (async, `i_rst`=0):
  - State goes to IDLE.
  - All outputs go to 0: `o_wr_en`, `o_wr_addr`, `o_wr_data`, `o_load_done`, `o_busy`, `o_word_count`.
  - The byte counter and shift register are cleared.
- IDLE:
  - `i_rx_done` is ignored.
  - `i_start` moves to COLLECT and clears the address, byte counter and `o_word_count`.
- COLLECT:
  - Each `i_rx_done` shifts the byte in: word = {word[23:0], i_rx_data}. The first byte received becomes bits [31:24].
  - A 2-bit byte counter increments on each byte and wraps 3→0.
  - When the 4th byte is captured, the next cycle drives `o_wr_en`=1 with `o_wr_data` = the completed word and `o_wr_addr` = the current address.
  - In that same write cycle, `o_word_count` increments and the address increments (no wrap; see full).
- Termination is evaluated on the completed word:
  - If word == `HALT_WORD`, or the address written is 2^N_ADDR−1, the next state after the write cycle is DONE.
  - Otherwise the state stays in COLLECT.
- DONE:
  - `o_load_done`=1; `o_wr_en`=0; `i_rx_done` is ignored.
  - `o_wr_addr`, `o_wr_data` and `o_word_count` hold their last values.
  - `i_start` returns to COLLECT with a fresh load from address 0.
- `i_start` during COLLECT is ignored. The load is not restarted; only reset aborts it.
- A partial word, with fewer than 4 bytes received, is never written. Reset discards it.

## Timing

- Latency: 4th-byte `i_rx_done` at edge N → `o_wr_en` high for exactly the cycle after edge N+1. `o_wr_en` is registered.
- `o_load_done` rises at the edge ending the write cycle of the terminating word, i.e. one cycle after that word's `o_wr_en`.
- `o_busy` rises one cycle after `i_start` and falls in the same edge as `o_load_done` rises.
- A byte arriving in the write cycle is accepted as byte 0 of the next word. Back-to-back `i_rx_done` on every cycle must therefore be sustained with no loss.
- Asserting `i_rst` mid-word or mid-write kills `o_wr_en` immediately (asynchronously). No write is issued after reset release until the next `i_start`.
- Simultaneous `i_start` and `i_rx_done` in IDLE/DONE: the move to COLLECT takes effect and the byte is ignored.

## Test plan

- Reset values: hold `i_rst`=0 for 10 ns with random `i_rx_done`/`i_start` → all outputs 0, no `o_wr_en`; release → state IDLE, outputs still 0.
- Basic load: `i_start`, then bytes 20,08,00,05, 8C,01,00,04, FF,FF,FF,FF →
  - writes (0, 32'h20080005), (1, 32'h8C010004), (2, 32'hFFFFFFFF);
  - `o_load_done`=1 one cycle after the third write; `o_word_count`=3.
- Back-to-back bytes: 8 bytes on consecutive cycles → two `o_wr_en` pulses, 4 cycles apart, with the correct words and no dropped byte.
- Memory full (`N_ADDR`=2): 16 non-HALT bytes → 4 writes at addresses 0..3, then DONE with `o_word_count`=4. A 17th byte produces no write.
- Reset mid-word: 2 bytes, then `i_rst` low → no write, outputs 0. After `i_start` and 4 new bytes, the write lands at address 0 with only the new bytes.
- Ignore rules: bytes in IDLE and DONE produce no write; `i_start` mid-COLLECT leaves address/count unchanged; `i_start` in DONE reloads from address 0 with `o_load_done` falling next cycle.

Source files
------------

// File: rtl/instruction_memory_loader.sv
// Byte-stream loader for the instruction memory: packs big-endian bytes
// into 32-bit words and writes them at consecutive word addresses.
module instruction_memory_loader #(
    parameter int               len       = 32,
    parameter int               N_ADDR    = 10,
    parameter logic [len-1:0]   HALT_WORD = 32'hFFFFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_data,
    output logic              o_wr_en,
    output logic [N_ADDR-1:0] o_wr_addr,
    output logic [len-1:0]    o_wr_data,
    output logic              o_load_done,
    output logic              o_busy,
    output logic [N_ADDR:0]   o_word_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [len-1:0]    word;
    logic [1:0]        byte_cnt;
    logic              word_rdy;
    logic [N_ADDR-1:0] addr;
    logic              byte_in;
    logic              start_ok;
    logic              last_wr;

    assign byte_in  = (state == COLLECT) && i_rx_done;
    assign start_ok = i_start && (state != COLLECT);

    // Termination is judged on the word being written this cycle.
    assign last_wr  = o_wr_en &&
                      ((o_wr_data == HALT_WORD) ||
                       (o_wr_addr == {N_ADDR{1'b1}}));

    assign o_busy      = (state == COLLECT);
    assign o_load_done = (state == DONE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (i_start) state_nx = COLLECT;
            COLLECT: if (last_wr) state_nx = DONE;
            DONE:    if (i_start) state_nx = COLLECT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word         <= '0;
            byte_cnt     <= '0;
            word_rdy     <= 1'b0;
            addr         <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_word_count <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if (start_ok) begin
                addr         <= '0;
                byte_cnt     <= '0;
                word_rdy     <= 1'b0;
                o_word_count <= '0;
            end else begin
                if (byte_in) begin
                    word     <= {word[len-9:0], i_rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                word_rdy <= byte_in && (byte_cnt == 2'd3);
                // Byte shift above keeps running, so a new word can
                // start in the same cycle this one is written.
                if (word_rdy) begin
                    o_wr_en      <= 1'b1;
                    o_wr_data    <= word;
                    o_wr_addr    <= addr;
                    addr         <= addr + 1'b1;
                    o_word_count <= o_word_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: vector table of loads plus
// hand sequences, writes checked against a queue scoreboard.
module tb_instruction_memory_loader;

    localparam int NA = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_rx_done = 1'b0;
    logic [7:0]    i_rx_data = 8'h00;
    logic          o_wr_en;
    logic [NA-1:0] o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          o_load_done;
    logic          o_busy;
    logic [NA:0]   o_word_count;

    instruction_memory_loader #(
        .len(32), .N_ADDR(NA), .HALT_WORD(32'hFFFFFFFF)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_load_done(o_load_done),
        .o_busy(o_busy), .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [NA-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic          st;
        logic [31:0]   w;
        int            gap;
        logic [NA-1:0] addr;
        logic          last;
    } vec_t;
    vec_t tv[8];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin : mon
        wr_t e;
        if (i_rst && o_wr_en) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                         o_wr_addr, o_wr_data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(o_wr_addr), 32'(e.addr));
                check("wr_data", o_wr_data, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge i_clk);
        #1;
        i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap,
                             input logic wr, input logic [NA-1:0] a);
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) idle(gap);
            send_byte(w[31-8*k -: 8]);
        end
        if (wr) begin
            e.addr = a;
            e.data = w;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{1'b1, 32'h20080005, 1, 2'd0, 1'b0};
        tv[1] = '{1'b0, 32'h8C010004, 0, 2'd1, 1'b0};
        tv[2] = '{1'b0, 32'hFFFFFFFF, 2, 2'd2, 1'b1};
        tv[3] = '{1'b1, 32'h01234567, 0, 2'd0, 1'b0};
        tv[4] = '{1'b0, 32'h89ABCDEF, 3, 2'd1, 1'b0};
        tv[5] = '{1'b0, 32'hFFFFFFFE, 1, 2'd2, 1'b0};
        tv[6] = '{1'b0, 32'h00000000, 0, 2'd3, 1'b1};
        tv[7] = '{1'b1, 32'hFFFFFFFF, 0, 2'd0, 1'b1};

        // reset with random activity on the inputs
        for (int k = 0; k < 10; k++) begin
            #1;
            i_rx_done = 1'($urandom_range(0, 1));
            i_start   = 1'($urandom_range(0, 1));
        end
        i_rx_done = 1'b0;
        i_start   = 1'b0;
        check("rst_wr_en", 32'(o_wr_en), 0);
        check("rst_wr_addr", 32'(o_wr_addr), 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_load_done", 32'(o_load_done), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_word_count", 32'(o_word_count), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        idle(2);
        check("idle_busy", 32'(o_busy), 0);
        check("idle_done", 32'(o_load_done), 0);

        // bytes in IDLE are dropped
        send_word(32'h12345678, 0, 1'b0, 0);
        idle(2);
        check("idle_ignore_count", 32'(o_word_count), 0);

        for (int i = 0; i < 8; i++) begin
            if (tv[i].st) begin
                pulse_start();
                check("busy_after_start", 32'(o_busy), 1);
                check("done_after_start", 32'(o_load_done), 0);
                check("count_cleared", 32'(o_word_count), 0);
            end
            send_word(tv[i].w, tv[i].gap, 1'b1, tv[i].addr);
            idle(1);
            check("wr_en_write_cycle", 32'(o_wr_en), 1);
            check("word_count", 32'(o_word_count), 32'(tv[i].addr) + 1);
            check("done_in_write_cycle", 32'(o_load_done), 0);
            idle(1);
            check("load_done", 32'(o_load_done), 32'(tv[i].last));
            check("busy", 32'(o_busy), 32'(!tv[i].last));
            check("wr_en_after", 32'(o_wr_en), 0);
        end

        // bytes in DONE are dropped, outputs hold
        send_word(32'h11223344, 0, 1'b0, 0);
        idle(2);
        check("done_hold_count", 32'(o_word_count), 1);
        check("done_hold_addr", 32'(o_wr_addr), 0);
        check("done_hold_data", o_wr_data, 32'hFFFFFFFF);
        check("done_hold_done", 32'(o_load_done), 1);

        // start together with a byte: byte is ignored
        i_start   = 1'b1;
        i_rx_done = 1'b1;
        i_rx_data = 8'hAA;
        @(posedge i_clk);
        #1;
        i_start   = 1'b0;
        i_rx_done = 1'b0;
        check("start_rx_busy", 32'(o_busy), 1);
        send_word(32'hDEADBEEF, 0, 1'b1, 0);

        // back-to-back bytes across three words
        send_word(32'hCAFEF00D, 0, 1'b1, 1);
        send_word(32'h0BADC0DE, 0, 1'b1, 2);
        send_word(32'hFFFFFFFF, 0, 1'b1, 3);
        idle(2);
        check("b2b_done", 32'(o_load_done), 1);
        check("b2b_count", 32'(o_word_count), 4);

        // start during COLLECT is ignored
        pulse_start();
        send_word(32'h00000001, 0, 1'b1, 0);
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_start();
        check("mid_start_busy", 32'(o_busy), 1);
        check("mid_start_count", 32'(o_word_count), 1);
        send_byte(8'h56);
        send_byte(8'h78);
        sb.push_back('{2'd1, 32'h12345678, cyc + 1});
        idle(1);
        check("mid_start_count2", 32'(o_word_count), 2);

        // reset mid-word discards the partial word
        send_byte(8'hAB);
        send_byte(8'hCD);
        #2;
        i_rst = 1'b0;
        #1;
        check("rstw_wr_en", 32'(o_wr_en), 0);
        check("rstw_count", 32'(o_word_count), 0);
        check("rstw_busy", 32'(o_busy), 0);
        check("rstw_data", o_wr_data, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        idle(2);
        send_word(32'h55555555, 0, 1'b0, 0);
        idle(2);
        pulse_start();
        send_word(32'h0A0B0C0D, 0, 1'b1, 0);
        idle(1);
        check("after_rst_addr", 32'(o_wr_addr), 0);

        // reset during the write cycle kills the strobe at once
        send_word(32'h01020304, 0, 1'b0, 0);
        @(posedge i_clk);
        #1;
        check("pre_rst_wr_en", 32'(o_wr_en), 1);
        i_rst = 1'b0;
        #1;
        check("async_rst_wr_en", 32'(o_wr_en), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        idle(3);
        check("post_rst_wr_en", 32'(o_wr_en), 0);
        check("post_rst_busy", 32'(o_busy), 0);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
